// File: rtl/fetch_predictor_if.sv
// rtl/fetch_predictor_if.sv - fetch address, EX redirect and BTB training bundle
interface fetch_predictor_if;
    logic        stall;
    logic        modify_pc;
    logic [31:0] update_pc;
    logic        update_btb;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] jump_addr;
    logic [31:0] pc;
    logic        predicted_taken;
    logic [31:0] pred_target;

    modport master (
        output stall, modify_pc, update_pc, update_btb, ex_pc, ex_taken, jump_addr,
        input  pc, predicted_taken, pred_target
    );

    modport slave (
        input  stall, modify_pc, update_pc, update_btb, ex_pc, ex_taken, jump_addr,
        output pc, predicted_taken, pred_target
    );
endinterface

// File: rtl/fetch_predictor.sv
// rtl/fetch_predictor.sv - fetch PC register with a direct-mapped BTB and 2-bit counters
module fetch_predictor #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    fetch_predictor_if.slave  bus
);
    localparam int ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W   = 32 - BTB_IDX_W - 2;

    logic [31:0]                   pc_q, pc_d;
    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [ENTRIES-1:0][31:0]      target_q;
    logic [ENTRIES-1:0][1:0]       cnt_q;

    logic [BTB_IDX_W-1:0] ridx;
    logic                 rhit;
    logic                 pred_taken;
    logic [31:0]          pred_tgt;

    logic [BTB_IDX_W-1:0] widx;
    logic [TAG_W-1:0]     wtag;
    logic                 whit;
    logic [31:0]          wtarget;
    logic [1:0]           wcnt;

    logic unused_low_bits;
    assign unused_low_bits = ^{bus.update_pc[1:0], bus.ex_pc[1:0]};

    // Lookup reads the registered state, so a same-cycle write is seen next cycle.
    always_comb begin
        ridx       = pc_q[BTB_IDX_W+1:2];
        rhit       = valid_q[ridx] && (tag_q[ridx] == pc_q[31:BTB_IDX_W+2]);
        pred_taken = rhit && cnt_q[ridx][1];
        pred_tgt   = rhit ? target_q[ridx] : 32'h0;
    end

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (bus.modify_pc) begin
            pc_d = {bus.update_pc[31:2], 2'b00};
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = {pred_tgt[31:2], 2'b00};
        end
    end

    always_comb begin
        widx    = bus.ex_pc[BTB_IDX_W+1:2];
        wtag    = bus.ex_pc[31:BTB_IDX_W+2];
        whit    = valid_q[widx] && (tag_q[widx] == wtag);
        wtarget = bus.jump_addr;
        wcnt    = bus.ex_taken ? 2'b10 : 2'b01;
        if (whit) begin
            if (bus.ex_taken) begin
                wcnt = (cnt_q[widx] == 2'b11) ? 2'b11 : cnt_q[widx] + 2'd1;
            end else begin
                wtarget = target_q[widx];
                wcnt    = (cnt_q[widx] == 2'b00) ? 2'b00 : cnt_q[widx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            cnt_q    <= {ENTRIES{2'b01}};
        end else begin
            pc_q <= pc_d;
            if (bus.update_btb) begin
                valid_q[widx]  <= 1'b1;
                tag_q[widx]    <= wtag;
                target_q[widx] <= wtarget;
                cnt_q[widx]    <= wcnt;
            end
        end
    end

    assign bus.pc              = pc_q;
    assign bus.predicted_taken = pred_taken;
    assign bus.pred_target     = pred_tgt;
endmodule

// File: tb/tb_fetch_predictor.sv
// tb/tb_fetch_predictor.sv - scoreboard bench for fetch_predictor against a behavioural BTB model
module tb_fetch_predictor;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int IDX_W = 4;
    localparam int N = 1 << IDX_W;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    fetch_predictor_if bus();

    fetch_predictor #(.RESET_PC(RST_PC), .BTB_IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int total = 0;
    int bad = 0;

    // Reference model: full trained PC kept per slot, counter as a clamped integer.
    bit          m_known = 0;
    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_tagpc [N];
    logic [31:0] m_target [N];
    int          m_cnt [N];

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
        return (a >> (IDX_W + 2)) == (b >> (IDX_W + 2));
    endfunction

    function automatic void model_lookup(input logic [31:0] a, output bit t, output logic [31:0] tg);
        int i;
        bit h;
        i  = slot(a);
        h  = m_valid[i] && same_tag(m_tagpc[i], a);
        t  = h && (m_cnt[i] >= 2);
        tg = h ? m_target[i] : 32'h0;
    endfunction

    function automatic void model_reset();
        m_pc = RST_PC;
        for (int i = 0; i < N; i++) begin
            m_valid[i]  = 0;
            m_tagpc[i]  = 32'h0;
            m_target[i] = 32'h0;
            m_cnt[i]    = 1;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input bit st, input bit md, input logic [31:0] up,
                        input bit ub, input logic [31:0] ep, input bit et, input logic [31:0] ja);
        bit          t;
        logic [31:0] tg;
        int          i;
        exp_t        e;
        if (m_known) begin
            model_lookup(m_pc, t, tg);
            e.pc = m_pc; e.taken = t; e.tgt = tg;
            sb_q.push_back(e);
        end
        rst            = r;
        bus.stall      = st;
        bus.modify_pc  = md;
        bus.update_pc  = up;
        bus.update_btb = ub;
        bus.ex_pc      = ep;
        bus.ex_taken   = et;
        bus.jump_addr  = ja;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
            m_known = 1;
        end else if (m_known) begin
            if (md)      m_pc = up & ~32'h3;
            else if (st) m_pc = m_pc;
            else if (t)  m_pc = tg & ~32'h3;
            else         m_pc = m_pc + 32'd4;
            if (ub) begin
                i = slot(ep);
                if (!(m_valid[i] && same_tag(m_tagpc[i], ep))) begin
                    m_valid[i]  = 1;
                    m_tagpc[i]  = ep;
                    m_target[i] = ja;
                    m_cnt[i]    = et ? 2 : 1;
                end else if (et) begin
                    m_target[i] = ja;
                    m_cnt[i]    = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
                end else begin
                    m_cnt[i]    = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect(input logic [31:0] a);
        step(0, 0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] ep, input bit et, input logic [31:0] ja);
        step(0, 0, 0, 0, 1, ep, et, ja);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc", bus.pc, e.pc);
                check("predicted_taken", {31'b0, bus.predicted_taken}, {31'b0, e.taken});
                check("pred_target", bus.pred_target, e.tgt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] up, ep, ja;
        int sel;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h40, 1, 32'h10, 1, 32'h80);
        idle(4);
        train(32'h10, 1, 32'h80);
        redirect(32'h10);
        idle(3);
        train(32'h10, 0, 32'h99);
        redirect(32'h10);
        idle(2);
        train(32'h10, 1, 32'h80);
        train(32'h50, 1, 32'h100);
        redirect(32'h10);
        idle(1);
        redirect(32'h50);
        idle(2);
        step(0, 1, 1, 32'h203, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int k = 0; k < 4; k++) train(32'h30, 1, 32'h120);
        train(32'h30, 0, 32'h0);
        redirect(32'h30);
        idle(2);
        for (int k = 0; k < 4; k++) train(32'h30, 0, 32'h0);
        train(32'h30, 1, 32'h140);
        redirect(32'h30);
        idle(1);
        train(32'h30, 1, 32'h160);
        redirect(32'h30);
        idle(2);
        redirect(32'hFFFF_FFFC);
        idle(2);
        step(1, 0, 1, 32'h40, 1, 32'h80, 1, 32'h44);
        idle(1);
        redirect(32'h50);
        idle(1);
        redirect(32'h80);
        idle(2);

        for (int k = 0; k < 3000; k++) begin
            up = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                              : 32'($urandom_range(0, 511));
            sel = $urandom_range(0, 3);
            case (sel)
                0:       ep = m_pc;
                1:       ep = m_pc + 32'd4;
                2:       ep = 32'($urandom_range(0, 15) << 4) | 32'($urandom_range(0, 3));
                default: ep = 32'($urandom_range(0, 511));
            endcase
            ja = 32'($urandom_range(0, 511));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 up, $urandom_range(0, 2) == 0, ep, $urandom_range(0, 1) == 1, ja);
        end
        idle(1);
        @(negedge clk);
        @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
